// File: rtl/instr_fetcher.sv
// Instruction fetcher with a direct-mapped instruction cache in front of program memory.
// Latency: a hit reaches FETCHED one cycle after FETCH is seen. A miss reaches FETCHED on the edge that samples mem_read_ready.
// Backpressure: one memory request at a time, held stable until mem_read_ready; FETCHED holds until the core reports DECODE.
//
// Ports:
//   clk, reset (async, active-high)
//   core_state, current_pc, invalidate   scheduler inputs
//   mem_read_valid/address/ready/data    program memory request/response
//   fetcher_state, instruction           fetch result
//   hit_count, miss_count                saturating cache statistics
module instr_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_ENTRIES         = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  localparam int IDX_BITS = $clog2(CACHE_ENTRIES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  state_t state;

  logic [CACHE_ENTRIES-1:0]         line_valid;
  logic [TAG_BITS-1:0]              line_tag  [CACHE_ENTRIES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data [CACHE_ENTRIES];

  // Lookup uses the live PC; the fill uses the captured request address,
  // since current_pc is free to move while the request is outstanding.
  logic [IDX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0] pc_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic                lookup_hit;
  logic                fill;

  assign pc_idx     = current_pc[IDX_BITS-1:0];
  assign pc_tag     = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  assign fill_idx   = mem_read_address[IDX_BITS-1:0];
  assign fill_tag   = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  assign lookup_hit = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
  assign fill       = (state == FETCHING) && mem_read_ready;

  assign fetcher_state = state;

  // Tag and data storage carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[fill_idx]  <= fill_tag;
      line_data[fill_idx] <= mem_read_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      line_valid       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lookup_hit) begin
              instruction <= line_data[pc_idx];
              state       <= FETCHED;
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              state            <= FETCHING;
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
          end
        end
        FETCHING: begin
          if (mem_read_ready) begin
            instruction          <= mem_read_data;
            mem_read_valid       <= 1'b0;
            line_valid[fill_idx] <= 1'b1;
            state                <= FETCHED;
          end
        end
        FETCHED: begin
          if (core_state == CORE_DECODE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed after the case so a coincident fill loses to the flush.
      if (invalidate) line_valid <= '0;
    end
  end

endmodule

// File: tb/tb_instr_fetcher.sv
module tb_instr_fetcher;

  localparam logic [2:0] CS_FETCH  = 3'b001;
  localparam logic [2:0] CS_DECODE = 3'b010;
  localparam logic [2:0] CS_OTHER  = 3'b000;
  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_FING   = 3'b001;
  localparam logic [2:0] ST_FED    = 3'b010;

  logic        clk;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  instr_fetcher dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .invalidate       (invalidate),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: program memory contents, a 4-line cache remembered as
  // (valid, full pc) per line, and the two statistics.
  typedef struct {
    logic [15:0] instr;
    logic [15:0] hits;
    logic [15:0] misses;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] mem [256];
  bit          mv  [4];
  logic [7:0]  mpc [4];
  logic [15:0] mhit;
  logic [15:0] mmiss;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
  endtask

  // Monitor: every entry into FETCHED is a delivered fetch result.
  logic [2:0] prev_state = ST_IDLE;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (fetcher_state == ST_FED && prev_state != ST_FED) begin
      if (expq.size() == 0) begin
        check("unexpected_fetched", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("instruction", instruction, e.instr);
        check("hit_count", hit_count, e.hits);
        check("miss_count", miss_count, e.misses);
      end
    end
    prev_state = fetcher_state;
  end

  // One complete fetch: request, optional memory wait, FETCHED hold, DECODE.
  task automatic fetch(input logic [7:0] pc, input int lat, input bit inv_req,
                       input bit inv_fill, input int hold, output bit was_hit);
    int   idx;
    exp_t e;
    idx     = int'(pc[1:0]);
    was_hit = mv[idx] && (mpc[idx] == pc);
    @(negedge clk);
    current_pc = pc;
    core_state = CS_FETCH;
    invalidate = inv_req;
    if (was_hit) begin
      mhit = sat_inc(mhit);
      e.instr = mem[pc]; e.hits = mhit; e.misses = mmiss;
      expq.push_back(e);
    end else begin
      mmiss = sat_inc(mmiss);
    end
    if (inv_req) model_flush();
    @(posedge clk); #1;
    invalidate = 1'b0;
    core_state = CS_OTHER;
    current_pc = 8'($urandom);
    if (was_hit) begin
      check("hit_state", fetcher_state, ST_FED);
      check("hit_no_req", mem_read_valid, 1'b0);
    end else begin
      check("miss_state", fetcher_state, ST_FING);
      check("miss_req", mem_read_valid, 1'b1);
      check("miss_addr", mem_read_address, pc);
      for (int i = 1; i < lat; i++) begin
        @(posedge clk); #1;
        check("wait_req", mem_read_valid, 1'b1);
        check("wait_addr", mem_read_address, pc);
      end
      @(negedge clk);
      mem_read_ready = 1'b1;
      mem_read_data  = mem[pc];
      invalidate     = inv_fill;
      e.instr = mem[pc]; e.hits = mhit; e.misses = mmiss;
      expq.push_back(e);
      if (inv_fill) model_flush();
      else begin mv[idx] = 1'b1; mpc[idx] = pc; end
      @(posedge clk); #1;
      mem_read_ready = 1'b0;
      invalidate     = 1'b0;
      mem_read_data  = 16'($urandom);
      check("fill_state", fetcher_state, ST_FED);
      check("fill_req_drop", mem_read_valid, 1'b0);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      core_state     = CS_FETCH;
      mem_read_ready = 1'($urandom);
      mem_read_data  = 16'($urandom);
      @(posedge clk); #1;
      check("hold_state", fetcher_state, ST_FED);
      check("hold_instr", instruction, mem[pc]);
    end
    @(negedge clk);
    mem_read_ready = 1'b0;
    core_state     = CS_DECODE;
    @(posedge clk); #1;
    check("decode_idle", fetcher_state, ST_IDLE);
    core_state = CS_OTHER;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    reset          = 1'b1;
    core_state     = CS_OTHER;
    current_pc     = 8'h00;
    invalidate     = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h05] = 16'hA1B2;
    model_flush();
    mhit = 16'd0; mmiss = 16'd0;

    @(posedge clk); #1;
    check("rst_state", fetcher_state, ST_IDLE);
    check("rst_req", mem_read_valid, 1'b0);
    check("rst_addr", mem_read_address, 8'h00);
    check("rst_instr", instruction, 16'h0000);
    check("rst_hits", hit_count, 16'h0000);
    check("rst_misses", miss_count, 16'h0000);
    @(negedge clk); reset = 1'b0;

    // Cold miss with three-cycle memory, then the hit on the same pc.
    fetch(8'h05, 3, 0, 0, 1, hit);
    check("first_is_miss", hit, 1'b0);
    fetch(8'h05, 1, 0, 0, 0, hit);
    check("second_is_hit", hit, 1'b1);
    // Conflict on index 1: 0x09 evicts 0x05, which then misses again.
    fetch(8'h09, 2, 0, 0, 0, hit);
    fetch(8'h05, 1, 0, 0, 0, hit);
    check("conflict_miss_count", miss_count, 16'd3);

    // Flush coincident with the fill: delivered, but not retained.
    fetch(8'h02, 2, 0, 1, 0, hit);
    fetch(8'h02, 1, 0, 0, 0, hit);
    check("post_flush_fill_miss", hit, 1'b0);
    // Flush coincident with a hit: the hit still counts, the line is gone after.
    fetch(8'h02, 1, 1, 0, 0, hit);
    check("flush_on_hit_is_hit", hit, 1'b1);
    fetch(8'h02, 1, 0, 0, 0, hit);
    check("after_flush_on_hit_miss", hit, 1'b0);

    // Reset in the second FETCHING cycle abandons the request.
    @(negedge clk);
    current_pc = 8'h33;
    core_state = CS_FETCH;
    @(posedge clk); #1;
    core_state = CS_OTHER;
    check("pre_rst_state", fetcher_state, ST_FING);
    @(posedge clk); #1;
    check("pre_rst_state2", fetcher_state, ST_FING);
    #1 reset = 1'b1;
    #1;
    check("async_rst_req", mem_read_valid, 1'b0);
    check("async_rst_state", fetcher_state, ST_IDLE);
    check("async_rst_misses", miss_count, 16'h0000);
    check("async_rst_instr", instruction, 16'h0000);
    model_flush();
    mhit = 16'd0; mmiss = 16'd0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    @(posedge clk); #1;
    mem_read_ready = 1'b0;
    check("late_ready_state", fetcher_state, ST_IDLE);
    check("late_ready_req", mem_read_valid, 1'b0);
    fetch(8'h33, 1, 0, 0, 0, hit);
    check("abandoned_not_cached", hit, 1'b0);

    // Randomized traffic over a small address pool so hits and conflicts occur.
    for (int n = 0; n < 60; n++) begin
      fetch(8'($urandom_range(0, 11)), int'($urandom_range(1, 4)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 2)), hit);
    end

    // Hit counter saturation.
    fetch(8'h40, 1, 0, 0, 0, hit);
    @(negedge clk);
    core_state = CS_OTHER;
    force dut.hit_count = 16'hFFFF;
    @(negedge clk);
    release dut.hit_count;
    mhit = 16'hFFFF;
    fetch(8'h40, 1, 0, 0, 0, hit);
    check("sat_is_hit", hit, 1'b1);
    @(negedge clk);
    check("sat_hit_count", hit_count, 16'hFFFF);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
